// File: rtl/mips_decode_pkg.sv
// MIPS instruction field positions and opcode constants shared by the fetch-to-decode buffer.
package mips_decode_pkg;

    localparam int INSTR_W = 32;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;

    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    localparam logic [5:0] OPC_RTYPE = 6'h00;

endpackage

// File: rtl/instr_fields.sv
// Combinational MIPS field slicer/extender with jump-target computation; zero latency,
// no backpressure. Every output is forced to 0 while i_vld is low.
module instr_fields
    import mips_decode_pkg::*;
#(
    parameter int PC_W = 32,
    parameter int XLEN = 32
) (
    input  logic               i_vld,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic [5:0]         o_opcode,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_rd,
    output logic [4:0]         o_shamnt,
    output logic [5:0]         o_fnct,
    output logic [XLEN-1:0]    o_imm_sext,
    output logic [XLEN-1:0]    o_imm_zext,
    output logic [PC_W-1:0]    o_jtarget,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_is_rtype
);

    // Only the 256 MB region bits of pc+4 survive into the jump target.
    localparam logic [PC_W-1:0] REGION_MASK = ~PC_W'(28'hFFF_FFFF);

    logic [IMM_W-1:0] w_imm;
    logic [PC_W-1:0]  w_pc4;
    logic [PC_W-1:0]  w_jt;

    assign w_imm = i_instr[IMM_W-1:0];
    assign w_pc4 = i_pc + PC_W'(4);
    assign w_jt  = (w_pc4 & REGION_MASK) | PC_W'({i_instr[JADDR_W-1:0], 2'b00});

    assign o_opcode   = i_vld ? i_instr[OPC_HI:OPC_LO] : '0;
    assign o_rs       = i_vld ? i_instr[RS_HI:RS_LO]   : '0;
    assign o_rt       = i_vld ? i_instr[RT_HI:RT_LO]   : '0;
    assign o_rd       = i_vld ? i_instr[RD_HI:RD_LO]   : '0;
    assign o_shamnt   = i_vld ? i_instr[SH_HI:SH_LO]   : '0;
    assign o_fnct     = i_vld ? i_instr[FN_HI:FN_LO]   : '0;
    assign o_imm_sext = i_vld ? XLEN'(signed'(w_imm))  : '0;
    assign o_imm_zext = i_vld ? XLEN'(w_imm)           : '0;
    assign o_jtarget  = i_vld ? w_jt                   : '0;
    assign o_pc       = i_vld ? i_pc                   : '0;
    assign o_is_rtype = i_vld && (i_instr[OPC_HI:OPC_LO] == OPC_RTYPE);

endmodule

// File: rtl/instr_decode_buf.sv
// Fetch-to-decode circular buffer presenting a pre-decoded head; push into empty is visible
// one edge later. in_ready drops when full (no same-cycle pass-through); head holds while stalled.
module instr_decode_buf
    import mips_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_opcode,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_shamnt,
    output logic [5:0]               out_fnct,
    output logic [XLEN-1:0]          out_imm_sext,
    output logic [XLEN-1:0]          out_imm_zext,
    output logic [PC_W-1:0]          out_jtarget,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_is_rtype,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = !rst && (r_count < DEPTH_C);
    assign out_valid = (r_count != '0);
    assign out_count = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
        end
    end

    instr_fields #(
        .PC_W (PC_W),
        .XLEN (XLEN)
    ) u_fields (
        .i_vld      (out_valid),
        .i_instr    (r_instr_mem[r_rd_ptr]),
        .i_pc       (r_pc_mem[r_rd_ptr]),
        .o_opcode   (out_opcode),
        .o_rs       (out_rs),
        .o_rt       (out_rt),
        .o_rd       (out_rd),
        .o_shamnt   (out_shamnt),
        .o_fnct     (out_fnct),
        .o_imm_sext (out_imm_sext),
        .o_imm_zext (out_imm_zext),
        .o_jtarget  (out_jtarget),
        .o_pc       (out_pc),
        .o_is_rtype (out_is_rtype)
    );

endmodule

// File: tb/tb_instr_decode_buf.sv
// Self-checking bench: decode vector table, hand-written corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_instr_decode_buf;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_opcode;
    logic [4:0]      out_rs, out_rt, out_rd, out_shamnt;
    logic [5:0]      out_fnct;
    logic [XLEN-1:0] out_imm_sext, out_imm_zext;
    logic [PC_W-1:0] out_jtarget, out_pc;
    logic            out_is_rtype;
    logic [CW-1:0]   out_count;

    instr_decode_buf #(.DEPTH(DEPTH), .PC_W(PC_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamnt(out_shamnt), .out_fnct(out_fnct),
        .out_imm_sext(out_imm_sext), .out_imm_zext(out_imm_zext),
        .out_jtarget(out_jtarget), .out_pc(out_pc), .out_is_rtype(out_is_rtype),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  opc;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [31:0] sext, zext, jt;
        logic        rtype;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the MIPS field definitions.
    task automatic check_model();
        bit          v;
        logic [31:0] i, p, imm, pc4;
        v   = (q_instr.size() != 0);
        i   = v ? q_instr[0] : 32'h0;
        p   = v ? q_pc[0]    : 32'h0;
        imm = i & 32'hFFFF;
        pc4 = p + 32'd4;
        chk("model.out_valid", out_valid, v);
        chk("model.in_ready", in_ready, !rst && (q_instr.size() < DEPTH));
        chk("model.count", out_count, q_instr.size());
        chk("model.opcode", out_opcode, v ? (i >> 26) : 0);
        chk("model.rs", out_rs, v ? ((i >> 21) % 32) : 0);
        chk("model.rt", out_rt, v ? ((i >> 16) % 32) : 0);
        chk("model.rd", out_rd, v ? ((i >> 11) % 32) : 0);
        chk("model.shamnt", out_shamnt, v ? ((i >> 6) % 32) : 0);
        chk("model.fnct", out_fnct, v ? (i % 64) : 0);
        chk("model.imm_sext", out_imm_sext, v ? (imm >= 32'h8000 ? imm + 32'hFFFF0000 : imm) : 0);
        chk("model.imm_zext", out_imm_zext, v ? imm : 0);
        chk("model.jtarget", out_jtarget, v ? ((pc4 & 32'hF000_0000) + ((i % 32'h0400_0000) * 4)) : 0);
        chk("model.pc", out_pc, p);
        chk("model.is_rtype", out_is_rtype, v && ((i >> 26) == 0));
    endtask

    // Starts just after a falling edge; ends on the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic rdy);
        int sz;
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = rdy;
        #1;
        check_model();
        @(posedge clk);
        sz = q_instr.size();
        if (fl) begin
            q_instr.delete(); q_pc.delete();
        end else begin
            if (sz != 0 && rdy) begin void'(q_instr.pop_front()); void'(q_pc.pop_front()); end
            if (v && sz < DEPTH) begin q_instr.push_back(ins); q_pc.push_back(pc); end
        end
        @(negedge clk);
    endtask

    task automatic idle_pop();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    vec_t        vecs[4];
    logic [31:0] pc_list[5];

    initial begin
        vecs[0] = '{32'h012A4020, 32'h00400000, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20,
                    32'h00004020, 32'h00004020, 32'h04A90080, 1'b1};
        vecs[1] = '{32'h2108FFFC, 32'h00400004, 6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3C,
                    32'hFFFFFFFC, 32'h0000FFFC, 32'h0423FFF0, 1'b0};
        vecs[2] = '{32'h08100004, 32'h0FFFFFFC, 6'h02, 5'd0, 5'd16, 5'd0, 5'd0, 6'h04,
                    32'h00000004, 32'h00000004, 32'h10400010, 1'b0};
        vecs[3] = '{32'h3C01ABCD, 32'hFFFFFFFC, 6'h0F, 5'd0, 5'd1, 5'd21, 5'd15, 6'h0D,
                    32'hFFFFABCD, 32'h0000ABCD, 32'h0006AF34, 1'b0};
        for (int k = 0; k < 5; k++) pc_list[k] = 32'h100 + 32'(4 * k);

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.in_ready", in_ready, 0);
        chk("reset.count", out_count, 0);
        chk("reset.out_pc", out_pc, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release.in_ready", in_ready, 1);
        @(negedge clk);

        // Decode table: each vector pushed into an empty buffer, checked, then popped.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, vecs[k].instr, vecs[k].pc, 1'b0, 1'b0);
            #1;
            chk("vec.out_valid", out_valid, 1);
            chk("vec.opcode", out_opcode, vecs[k].opc);
            chk("vec.rs", out_rs, vecs[k].rs);
            chk("vec.rt", out_rt, vecs[k].rt);
            chk("vec.rd", out_rd, vecs[k].rd);
            chk("vec.shamnt", out_shamnt, vecs[k].sh);
            chk("vec.fnct", out_fnct, vecs[k].fn);
            chk("vec.imm_sext", out_imm_sext, vecs[k].sext);
            chk("vec.imm_zext", out_imm_zext, vecs[k].zext);
            chk("vec.jtarget", out_jtarget, vecs[k].jt);
            chk("vec.pc", out_pc, vecs[k].pc);
            chk("vec.is_rtype", out_is_rtype, vecs[k].rtype);
            idle_pop();
        end

        // Fill to capacity with decode stalled; the fifth offer must be refused.
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'h2000_0000 + 32'(k), pc_list[k], 1'b0, 1'b0);
        #1;
        chk("full.count", out_count, 4);
        chk("full.in_ready", in_ready, 0);
        chk("full.head_pc", out_pc, pc_list[0]);
        idle_pop();
        #1;
        chk("drain.head_pc1", out_pc, pc_list[1]);
        idle_pop();
        #1;
        chk("drain.count2", out_count, 2);
        chk("drain.head_pc2", out_pc, pc_list[2]);
        cycle(1'b1, 32'h2000_0005, 32'h114, 1'b0, 1'b1);
        #1;
        chk("pushpop.count", out_count, 2);
        chk("pushpop.head_pc", out_pc, pc_list[3]);
        idle_pop();
        #1;
        chk("drain.head_after", out_pc, 32'h114);
        idle_pop();
        #1;
        chk("drain.empty", out_valid, 0);

        // Flush with a simultaneous offer: nothing survives.
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h2400_0000 + 32'(k), 32'h200 + 32'(4 * k), 1'b0, 1'b0);
        #1;
        chk("flush.pre_count", out_count, 3);
        cycle(1'b1, 32'hDEADBEEF, 32'h1234, 1'b1, 1'b1);
        #1;
        chk("flush.count", out_count, 0);
        chk("flush.out_valid", out_valid, 0);
        repeat (2) idle_pop();
        cycle(1'b1, 32'h2108FFFC, 32'h300, 1'b0, 1'b0);
        #1;
        chk("flush.next_pc", out_pc, 32'h300);
        chk("flush.next_count", out_count, 1);
        idle_pop();

        // Asynchronous reset between edges with three entries held.
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h2800_0000 + 32'(k), 32'h400 + 32'(4 * k), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.in_ready", in_ready, 0);
        chk("arst.count", out_count, 0);
        chk("arst.opcode", out_opcode, 0);
        chk("arst.rs", out_rs, 0);
        chk("arst.rt", out_rt, 0);
        chk("arst.imm_sext", out_imm_sext, 0);
        chk("arst.jtarget", out_jtarget, 0);
        chk("arst.pc", out_pc, 0);
        q_instr.delete(); q_pc.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst.release_ready", in_ready, 1);
        cycle(1'b1, 32'h012A4020, 32'h00400000, 1'b0, 1'b0);
        #1;
        chk("arst.new_rs", out_rs, 9);
        chk("arst.new_rd", out_rd, 8);
        chk("arst.new_fnct", out_fnct, 6'h20);
        chk("arst.new_pc", out_pc, 32'h00400000);
        idle_pop();

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'h0FFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                              : ($urandom & 32'hFFFF_FFFC);
            cycle($urandom_range(0, 3) != 0, $urandom, rpc,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end
        #1;
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
